// File: rtl/byte_stream_word_assembler_if.sv
// Byte-stream input / extracted-word output bundle for byte_stream_word_assembler.
// SignExt_i exists only when BYTE2WORD_SIGNEXT_EN is defined.
interface byte_stream_word_assembler_if #(
  parameter int unsigned WordWidth = 16
);
  logic                 Enable_i;
  logic                 Clear_i;
  logic [7:0]           Data_i;
  logic                 DataValid_i;
  logic                 MsbFirst_i;
  logic [4:0]           Shift_i;
  logic [5:0]           Mask_i;
`ifdef BYTE2WORD_SIGNEXT_EN
  logic                 SignExt_i;
`endif
  logic [WordWidth-1:0] Word_o;
  logic                 WordValid_o;
  logic                 Busy_o;
  logic                 FrameError_o;

  modport slave (
    input  Enable_i, Clear_i, Data_i, DataValid_i, MsbFirst_i, Shift_i, Mask_i,
`ifdef BYTE2WORD_SIGNEXT_EN
    input  SignExt_i,
`endif
    output Word_o, WordValid_o, Busy_o, FrameError_o
  );

  modport master (
    output Enable_i, Clear_i, Data_i, DataValid_i, MsbFirst_i, Shift_i, Mask_i,
`ifdef BYTE2WORD_SIGNEXT_EN
    output SignExt_i,
`endif
    input  Word_o, WordValid_o, Busy_o, FrameError_o
  );
endinterface

// File: rtl/byte_stream_word_assembler.sv
// Collects NumBytes bytes into a frame, then extracts a shifted/masked field as Word_o.
// Optional sign extension of the field is compiled in with BYTE2WORD_SIGNEXT_EN.
module byte_stream_word_assembler #(
  parameter int unsigned NumBytes      = 2,
  parameter int unsigned WordWidth     = 16,
  parameter int unsigned TimeoutCycles = 0
) (
  input logic                         Clk_i,
  input logic                         Reset_n_i,
  byte_stream_word_assembler_if.slave bus
);

  localparam int unsigned FrameWidth = 8 * NumBytes;
  localparam int unsigned CntWidth   = (NumBytes > 2) ? 2 : 1;
  localparam int unsigned IdleWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0]  LastCnt  = CntWidth'(NumBytes - 1);
  localparam logic [IdleWidth-1:0] IdleLast = IdleWidth'(TimeoutCycles - 1);

  // Collect stage
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [FrameWidth-1:0] frame_q, frame_d;
  logic                  order_q, order_d;
  logic [IdleWidth-1:0]  idle_q, idle_d;
  logic                  frame_error_q, frame_error_d;

  // Result stage: completed frame plus the extraction controls sampled with it
  logic                  res_valid_q, res_valid_d;
  logic [FrameWidth-1:0] res_frame_q;
  logic [4:0]            res_shift_q;
  logic [5:0]            res_mask_q;
`ifdef BYTE2WORD_SIGNEXT_EN
  logic                  res_sext_q;
`endif

  // Output stage
  logic [WordWidth-1:0]  word_q, word_d;
  logic                  word_valid_q;

  logic                  accept;
  logic                  first_byte;
  logic                  last_byte;
  logic                  msb_sel;

  logic [FrameWidth-1:0] shifted;
  logic [FrameWidth-1:0] keep;
  logic [FrameWidth-1:0] field;
`ifdef BYTE2WORD_SIGNEXT_EN
  logic [63:0]           field_ext;
  logic                  sign_bit;
`endif

  assign accept     = bus.Enable_i & bus.DataValid_i & ~bus.Clear_i;
  assign first_byte = (cnt_q == '0);
  assign last_byte  = (cnt_q == LastCnt);
  // The order bit only becomes live once the first byte has been taken
  assign msb_sel    = first_byte ? bus.MsbFirst_i : order_q;

  always_comb begin
    cnt_d         = cnt_q;
    frame_d       = frame_q;
    order_d       = order_q;
    idle_d        = idle_q;
    frame_error_d = 1'b0;
    res_valid_d   = 1'b0;

    if (bus.Clear_i) begin
      cnt_d  = '0;
      idle_d = '0;
    end else if (accept) begin
      if (first_byte) begin
        order_d = bus.MsbFirst_i;
      end
      if (msb_sel) begin
        frame_d = {frame_q[FrameWidth-9:0], bus.Data_i};
      end else begin
        frame_d = {bus.Data_i, frame_q[FrameWidth-1:8]};
      end
      cnt_d       = last_byte ? '0 : cnt_q + 1'b1;
      idle_d      = '0;
      res_valid_d = last_byte;
    end else if ((TimeoutCycles != 0) && bus.Enable_i && !first_byte) begin
      // An accepted byte takes the branch above, so it always beats expiry
      if (idle_q == IdleLast) begin
        cnt_d         = '0;
        idle_d        = '0;
        frame_error_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_comb begin
    shifted = res_frame_q >> res_shift_q;
    keep    = '0;
    for (int i = 0; i < int'(FrameWidth); i++) begin
      keep[i] = (i < int'(res_mask_q));
    end
    field  = shifted & keep;
    word_d = field[WordWidth-1:0];
`ifdef BYTE2WORD_SIGNEXT_EN
    field_ext = 64'(field);
    sign_bit  = field_ext[res_mask_q - 6'd1];
    if (res_sext_q && (res_mask_q != '0) && (32'(res_mask_q) < WordWidth)) begin
      for (int i = 0; i < int'(WordWidth); i++) begin
        if (i >= int'(res_mask_q)) begin
          word_d[i] = sign_bit;
        end
      end
    end
`endif
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      cnt_q         <= '0;
      frame_q       <= '0;
      order_q       <= 1'b0;
      idle_q        <= '0;
      frame_error_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_frame_q   <= '0;
      res_shift_q   <= '0;
      res_mask_q    <= '0;
`ifdef BYTE2WORD_SIGNEXT_EN
      res_sext_q    <= 1'b0;
`endif
      word_q        <= '0;
      word_valid_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      order_q       <= order_d;
      idle_q        <= idle_d;
      frame_error_q <= frame_error_d;
      res_valid_q   <= res_valid_d;
      if (res_valid_d) begin
        res_frame_q <= frame_d;
        res_shift_q <= bus.Shift_i;
        res_mask_q  <= bus.Mask_i;
`ifdef BYTE2WORD_SIGNEXT_EN
        res_sext_q  <= bus.SignExt_i;
`endif
      end
      word_valid_q <= res_valid_q;
      if (res_valid_q) begin
        word_q <= word_d;
      end
    end
  end

  assign bus.Word_o       = word_q;
  assign bus.WordValid_o  = word_valid_q;
  assign bus.Busy_o       = (cnt_q != '0);
  assign bus.FrameError_o = frame_error_q;

endmodule

// File: tb/tb_byte_stream_word_assembler.sv
// Directed plus randomized checks of byte_stream_word_assembler (NumBytes=2, WordWidth=16,
// TimeoutCycles=8) against an arithmetic reference model.
module tb_byte_stream_word_assembler;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  byte_stream_word_assembler_if #(.WordWidth(16)) bus ();

  byte_stream_word_assembler #(
    .NumBytes     (2),
    .WordWidth    (16),
    .TimeoutCycles(8)
  ) dut (
    .Clk_i    (clk),
    .Reset_n_i(rst_n),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Value of the frame as a number, then shift, mask and optional sign fill.
  function automatic logic [15:0] ref_word(input logic [7:0] first, input logic [7:0] second,
                                           input bit msb, input int sh, input int mk,
                                           input bit sx);
    longint unsigned v;
    longint unsigned f;
    logic [15:0]     r;
    v = msb ? (longint'(first) * 256 + longint'(second))
            : (longint'(second) * 256 + longint'(first));
    f = (sh >= 16) ? 64'd0 : (v >> sh);
    if (mk < 16) f = f % (64'd1 << mk);
    r = 16'(f);
    if (sx && mk > 0 && mk < 16 && f[mk-1]) r = r | (16'hFFFF << mk);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.Data_i      = b;
    bus.DataValid_i = 1'b1;
    step();
    bus.DataValid_i = 1'b0;
  endtask

  logic [7:0]  b0, b1;
  logic [15:0] exp_w, held;
  bit          m, sx;
  int          sh, mk, gap;

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.Enable_i    = 1'b0;
    bus.Clear_i     = 1'b0;
    bus.Data_i      = 8'h00;
    bus.DataValid_i = 1'b0;
    bus.MsbFirst_i  = 1'b1;
    bus.Shift_i     = 5'd0;
    bus.Mask_i      = 6'd0;
`ifdef BYTE2WORD_SIGNEXT_EN
    bus.SignExt_i   = 1'b0;
`endif
    repeat (3) step();
    check("reset_word", 32'(bus.Word_o), 32'h0);
    check("reset_valid", 32'(bus.WordValid_o), 32'd0);
    check("reset_busy", 32'(bus.Busy_o), 32'd0);
    check("reset_err", 32'(bus.FrameError_o), 32'd0);
    rst_n        = 1'b1;
    bus.Enable_i = 1'b1;
    step();

    // MSB-first A5 3C, shift 5 mask 11
    bus.MsbFirst_i = 1'b1; bus.Shift_i = 5'd5; bus.Mask_i = 6'd11;
    send(8'hA5);
    check("msb_busy_mid", 32'(bus.Busy_o), 32'd1);
    send(8'h3C);
    check("msb_latency_valid", 32'(bus.WordValid_o), 32'd0);
    check("msb_busy_done", 32'(bus.Busy_o), 32'd0);
    step();
    check("msb_valid", 32'(bus.WordValid_o), 32'd1);
    check("msb_word", 32'(bus.Word_o), 32'h0529);
    step();
    check("msb_valid_pulse", 32'(bus.WordValid_o), 32'd0);
    check("msb_word_held", 32'(bus.Word_o), 32'h0529);

    // LSB-first 3C A5, MsbFirst flipped mid-frame must be ignored
    bus.MsbFirst_i = 1'b0;
    send(8'h3C);
    bus.MsbFirst_i = 1'b1;
    send(8'hA5);
    step();
    check("lsb_word", 32'(bus.Word_o), 32'h0529);

    // Full word, back-to-back with the next frame's first byte
    bus.MsbFirst_i = 1'b1; bus.Shift_i = 5'd0; bus.Mask_i = 6'd16;
    send(8'hA5);
    send(8'h3C);
    send(8'h77);
    check("b2b_valid", 32'(bus.WordValid_o), 32'd1);
    check("b2b_word", 32'(bus.Word_o), 32'hA53C);
    check("b2b_busy", 32'(bus.Busy_o), 32'd1);
    send(8'h01);
    step();
    check("b2b_second_word", 32'(bus.Word_o), 32'h7701);

`ifdef BYTE2WORD_SIGNEXT_EN
    bus.Shift_i = 5'd5; bus.Mask_i = 6'd11; bus.SignExt_i = 1'b1;
    send(8'hA5);
    send(8'h3C);
    step();
    check("sext_on", 32'(bus.Word_o), 32'hFD29);
    bus.SignExt_i = 1'b0;
    send(8'hA5);
    send(8'h3C);
    step();
    check("sext_off", 32'(bus.Word_o), 32'h0529);
`endif

    // Timeout after 8 idle cycles
    bus.Shift_i = 5'd0; bus.Mask_i = 6'd16;
    held = bus.Word_o;
    send(8'h11);
    repeat (7) step();
    check("to_no_err_yet", 32'(bus.FrameError_o), 32'd0);
    check("to_busy_yet", 32'(bus.Busy_o), 32'd1);
    step();
    check("to_err", 32'(bus.FrameError_o), 32'd1);
    check("to_busy", 32'(bus.Busy_o), 32'd0);
    check("to_word_held", 32'(bus.Word_o), 32'(held));
    step();
    check("to_err_pulse", 32'(bus.FrameError_o), 32'd0);
    send(8'h12);
    send(8'h34);
    step();
    check("to_next_word", 32'(bus.Word_o), 32'h1234);

    // Byte arriving on the expiry cycle wins
    send(8'h56);
    repeat (7) step();
    send(8'h78);
    check("to_race_err", 32'(bus.FrameError_o), 32'd0);
    step();
    check("to_race_valid", 32'(bus.WordValid_o), 32'd1);
    check("to_race_word", 32'(bus.Word_o), 32'h5678);

    // Clear with the second byte discards the frame
    send(8'hAA);
    bus.Clear_i = 1'b1;
    send(8'h55);
    bus.Clear_i = 1'b0;
    check("clr_busy", 32'(bus.Busy_o), 32'd0);
    step();
    check("clr_no_valid", 32'(bus.WordValid_o), 32'd0);
    send(8'hBE);
    send(8'hEF);
    // Clear right after the last byte does not cancel the word
    bus.Clear_i = 1'b1;
    step();
    bus.Clear_i = 1'b0;
    check("clr_late_valid", 32'(bus.WordValid_o), 32'd1);
    check("clr_late_word", 32'(bus.Word_o), 32'hBEEF);

    // Reset mid-frame
    send(8'hC3);
    rst_n = 1'b0;
    #2;
    check("rst_word", 32'(bus.Word_o), 32'h0);
    check("rst_busy", 32'(bus.Busy_o), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_no_valid", 32'(bus.WordValid_o), 32'd0);
    check("rst_no_err", 32'(bus.FrameError_o), 32'd0);
    send(8'h9A);
    send(8'hBC);
    step();
    check("rst_next_word", 32'(bus.Word_o), 32'h9ABC);

    // Enable low for 20 cycles mid-frame freezes everything
    send(8'h4D);
    bus.Enable_i    = 1'b0;
    bus.DataValid_i = 1'b1;
    bus.Data_i      = 8'hFF;
    repeat (20) step();
    check("en_busy", 32'(bus.Busy_o), 32'd1);
    check("en_no_err", 32'(bus.FrameError_o), 32'd0);
    bus.DataValid_i = 1'b0;
    bus.Enable_i    = 1'b1;
    send(8'h2E);
    check("en_no_err2", 32'(bus.FrameError_o), 32'd0);
    step();
    check("en_word", 32'(bus.Word_o), 32'h4D2E);

    // Randomized frames against the reference model
    for (int n = 0; n < 40; n++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      m  = 1'($urandom_range(0, 1));
      sh = int'($urandom_range(0, 31));
      mk = int'($urandom_range(0, 63));
      sx = 1'b0;
`ifdef BYTE2WORD_SIGNEXT_EN
      sx = 1'($urandom_range(0, 1));
      bus.SignExt_i = sx;
`endif
      bus.MsbFirst_i = m;
      bus.Shift_i    = 5'(sh);
      bus.Mask_i     = 6'(mk);
      send(b0);
      bus.MsbFirst_i = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 3));
      repeat (gap) step();
      send(b1);
      bus.Shift_i = 5'($urandom);
      bus.Mask_i  = 6'($urandom);
      exp_w = ref_word(b0, b1, m, sh, mk, sx);
      step();
      check("rand_valid", 32'(bus.WordValid_o), 32'd1);
      check("rand_word", 32'(bus.Word_o), 32'(exp_w));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_stream_word_assembler.md
# byte_stream_word_assembler

Assembles a serial stream of bytes, as delivered by the SPI/I2C masters in the sensor-node SoC, into one word per frame. It then extracts a bit field from that word with a run-time shift and mask and presents the result with a one-cycle valid strobe. It generalises the combinational two-byte select cell: the byte count is parametrised, byte order is selectable, output is registered, and frames are tracked with abort and timeout handling.

## Interface
Parameters:
- NumBytes, 2: bytes per frame; legal 2..4.
- WordWidth, 16: width of Word_o; legal 1..8*NumBytes.
- TimeoutCycles, 0: idle cycles allowed between bytes inside a frame; 0 disables the timeout.

Ports:
- Clk_i  in  1  clock.
- Reset_n_i  in  1  asynchronous, active-low reset.
- Enable_i  in  1  block enable; while low, DataValid_i is ignored and the timeout counter holds.
- Clear_i  in  1  synchronous frame abort.
- Data_i  in  8  incoming byte.
- DataValid_i  in  1  Data_i is valid this cycle.
- MsbFirst_i  in  1  1: first byte is the most significant; 0: first byte is the least significant.
- Shift_i  in  5  right shift applied to the assembled frame.
- Mask_i  in  6  number of LSBs kept after the shift; 0 keeps none.
- SignExt_i  in  1  sign-extend the kept field (present only with BYTE2WORD_SIGNEXT_EN).
- Word_o  out  WordWidth  extracted field; holds its value between frames.
- WordValid_o  out  1  one-cycle pulse: Word_o was updated.
- Busy_o  out  1  a frame is partially received.
- FrameError_o  out  1  one-cycle pulse: a frame was aborted by timeout.

## Operation
- State is a byte counter Cnt (0..NumBytes-1), a frame shift register Frame[8*NumBytes-1:0] and a latched order bit. IDLE is Cnt==0; COLLECT is Cnt>0. Busy_o = (Cnt != 0).
- A byte is accepted when Enable_i=1, DataValid_i=1 and Clear_i=0.
- First byte (Cnt==0): MsbFirst_i is latched for the whole frame. Later changes of MsbFirst_i inside the frame have no effect.
- MSB-first: Frame <= {Frame[8*NumBytes-9:0], Data_i}.
- LSB-first: Frame <= {Data_i, Frame[8*NumBytes-1:8]}.
- Last byte (Cnt==NumBytes-1): Cnt returns to 0. On the same edge, Shift_i and Mask_i (and SignExt_i, when compiled in) are sampled into the result stage, together with the completed frame.
- Result stage: R = (Frame >> Shift); F = R & ((1<<Mask)-1).
  - Mask >= 8*NumBytes keeps all bits.
  - Shift >= 8*NumBytes yields 0.
  - Word_o = F truncated or zero-extended to WordWidth.
- Clear_i=1: Cnt <= 0 and the timeout counter <= 0.
  - A byte presented in the same cycle is discarded.
  - Clear_i does not cancel a word whose last byte was accepted on the previous edge; that WordValid_o still pulses.
- Timeout (TimeoutCycles>0): in COLLECT with Enable_i=1, an idle counter increments on every cycle without an accepted byte and resets on every accepted byte.
  - When it reaches TimeoutCycles: Cnt <= 0, FrameError_o pulses for one cycle, Word_o is unchanged.
  - A byte accepted in the same cycle as the expiry wins: no error is raised.
- Enable_i low mid-frame freezes Cnt, Frame and the idle counter. The frame resumes when Enable_i returns high.

## Timing
- Reset values: Word_o=0, WordValid_o=0, Busy_o=0, FrameError_o=0, Cnt=0, idle counter=0.
- Reset asserted mid-frame discards the partial frame. Nothing is pulsed after reset is released.
- Latency: WordValid_o and the new Word_o appear on the edge after the edge that accepts the last byte, i.e. 1 cycle.
- Throughput: one byte per cycle. The last byte of frame N may be followed directly by the first byte of frame N+1; WordValid_o for N then coincides with Busy_o=1 for N+1.
- FrameError_o is registered and rises on the edge where the idle count reaches TimeoutCycles.
- No backpressure: the consumer must take Word_o on the WordValid_o cycle or read the held value later.

## Configuration
- BYTE2WORD_SIGNEXT_EN defined: the SignExt_i port exists.
  - With SignExt_i=1 and 0<Mask<WordWidth, bit Mask-1 of F fills Word_o[WordWidth-1:Mask].
  - SignExt_i=0 behaves as zero-fill.
- Not defined: the SignExt_i port is absent and Word_o is always zero-filled above Mask.

## Test plan
- NumBytes=2, WordWidth=16, MSB-first; bytes 0xA5, 0x3C on consecutive cycles; Shift=5, Mask=11 -> Word_o=0x0529, WordValid_o high for exactly 1 cycle, 1 cycle after the second byte.
- Same settings, LSB-first; bytes 0x3C, 0xA5 -> Word_o=0x0529. Then Shift=0, Mask=16 with bytes 0xA5, 0x3C MSB-first -> Word_o=0xA53C.
- BYTE2WORD_SIGNEXT_EN defined, first scenario with SignExt_i=1 -> Word_o=0xFD29. With SignExt_i=0 -> 0x0529.
- TimeoutCycles=8: one byte 0x11, then 8 idle cycles -> FrameError_o pulses, Busy_o=0, Word_o unchanged. Next bytes 0x12, 0x34 (Shift=0, Mask=16) -> Word_o=0x1234.
- Clear_i together with the second byte of a frame -> no WordValid_o, Busy_o=0. Next frame 0xBE, 0xEF -> Word_o=0xBEEF.
- Reset_n_i pulsed low after the first byte -> all outputs 0. Enable_i low between two bytes for 20 cycles with TimeoutCycles=8 -> no FrameError_o, and the frame completes correctly.
